// File: rtl/uart_tx.sv
// 8N1 UART transmitter with internal oversampling baud divider.
// A new frame needs tx_start to be seen low first, so a held request sends exactly one byte.
module uart_tx #(
  parameter int D_BIT   = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_dato_in,
  output logic       tx_done,
  output logic       tx_busy,
  output logic       tx
);

  localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;

  localparam logic [3:0] S_IDLE  = 4'b0001;
  localparam logic [3:0] S_START = 4'b0010;
  localparam logic [3:0] S_DATA  = 4'b0100;
  localparam logic [3:0] S_STOP  = 4'b1000;

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    s_q, s_d;
  logic [2:0]    n_q, n_d;
  logic [7:0]    sh_q, sh_d;
  logic          armed_q, armed_d;
  logic          tx_q, tx_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic          tick, launch;

  assign tick   = (state_q != S_IDLE) && (cnt_q == CW'(DVSR - 1));
  assign launch = (state_q == S_IDLE) && tx_start && armed_q;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    sh_d    = sh_q;
    done_d  = 1'b0;
    armed_d = launch ? 1'b0 : (armed_q | ~tx_start);
    busy_d  = launch ? 1'b1 : (done_q ? 1'b0 : busy_q);

    if (state_q == S_IDLE) cnt_d = '0;
    else if (tick)         cnt_d = '0;
    else                   cnt_d = cnt_q + CW'(1);

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          sh_d    = tx_dato_in;
          s_d     = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          if (s_q == 5'd15) begin
            s_d     = '0;
            n_d     = '0;
            state_d = S_DATA;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (s_q == 5'd15) begin
            s_d  = '0;
            sh_d = sh_q >> 1;
            if (n_q == 3'(D_BIT - 1)) state_d = S_STOP;
            else                      n_d     = n_q + 3'd1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (s_q == 5'(SB_TICK - 1)) begin
            s_d     = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line level follows the next state so tx changes on the same edge as the FSM.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      s_q     <= '0;
      n_q     <= '0;
      sh_q    <= '0;
      armed_q <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      n_q     <= n_d;
      sh_q    <= sh_d;
      armed_q <= armed_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign tx      = tx_q;
  assign tx_done = done_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-position model checked every cycle, plus directed literal frame checks.
module tb_uart_tx;
  localparam int DVSR = 4;
  localparam int BIT  = 16 * DVSR;
  localparam int L    = (16 * 9 + 16) * DVSR;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic [7:0] tx_dato_in;
  logic       tx_done, tx_busy, tx;

  int checks = 0, failures = 0;
  int done_cnt = 0, run = 0, last_run = 0;

  uart_tx #(.D_BIT(8), .SB_TICK(16), .DVSR(DVSR)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_dato_in(tx_dato_in),
    .tx_done(tx_done), .tx_busy(tx_busy), .tx(tx)
  );

  always #5 clk = ~clk;

  // Model: pos = clocks since first low cycle of the frame, -1 when idle, L in the done cycle.
  int         pos = -1;
  logic       m_armed = 1'b0;
  logic [7:0] m_data = 8'h00;
  wire        m_launch = (pos < 0 || pos == L) && tx_start && m_armed;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pos     <= -1;
      m_armed <= 1'b0;
    end else begin
      if (!tx_start) m_armed <= 1'b1;
      if (m_launch) begin
        m_armed <= 1'b0;
        m_data  <= tx_dato_in;
        pos     <= 0;
      end else if (pos == L) pos <= -1;
      else if (pos >= 0)     pos <= pos + 1;
    end
  end

  // {tx, tx_done, tx_busy} expected for frame position p
  function automatic logic [2:0] m_exp(input int p, input logic [7:0] d);
    int b;
    if (p < 0)  return 3'b100;
    if (p == L) return 3'b111;
    b = p / BIT;
    if (b == 0) return 3'b001;
    if (b <= 8) return {d[b-1], 2'b01};
    return 3'b101;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("model_cycle", {29'd0, tx, tx_done, tx_busy}, {29'd0, m_exp(pos, m_data)});
      if (tx_done === 1'b1) done_cnt++;
      if (tx === 1'b0) run++;
      else begin
        if (run > 0) last_run = run;
        run = 0;
      end
    end
  end

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (tx_done !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    if (tx_done !== 1'b1) check({nm, "_done_timeout"}, 0, 1);
  endtask

  // Samples each frame bit at its centre; exp_bits[k] is frame bit k (bit 0 = start).
  task automatic capture(input string nm, input logic [9:0] exp_bits, input bit disturb);
    logic [9:0] got;
    int n, k;
    got = '0;
    n = 0;
    while (tx !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    if (tx !== 1'b0) begin
      check({nm, "_fall_timeout"}, 0, 1);
      return;
    end
    n = 0;
    k = 0;
    while (k < 10) begin
      @(negedge clk);
      n++;
      if (n == BIT / 2 + BIT * k) begin
        got[k] = tx;
        if (disturb && k == 4) begin
          tx_dato_in = 8'hF0;
          tx_start   = 1'b0;
        end
        k++;
      end
    end
    while (tx_done !== 1'b1 && n < L + 100) begin @(negedge clk); n++; end
    check({nm, "_bits"}, {22'd0, got}, {22'd0, exp_bits});
    check({nm, "_done_at"}, n, L);
  endtask

  initial begin
    int base, lows, gap, n;
    reset = 1'b1;
    tx_start = 1'b0;
    tx_dato_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_state", {29'd0, tx, tx_done, tx_busy}, 32'h4);
    reset = 1'b0;

    repeat (1000) @(negedge clk);
    check("idle_no_done", done_cnt, 0);

    // single 0x55
    base = done_cnt;
    tx_dato_in = 8'h55;
    tx_start = 1'b1;
    capture("b55", 10'b1010101010, 1'b0);
    tx_start = 1'b0;
    repeat (5) @(negedge clk);
    check("b55_one_done", done_cnt - base, 1);

    // held request sends one frame only
    base = done_cnt;
    tx_dato_in = 8'hA3;
    tx_start = 1'b1;
    capture("bA3", 10'b1101000110, 1'b0);
    lows = 0;
    repeat (2300) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("held_line_idle", lows, 0);
    check("held_one_done", done_cnt - base, 1);
    tx_start = 1'b0;
    repeat (5) @(negedge clk);

    // back-to-back 0x00 then 0xFF with handshake
    tx_dato_in = 8'h00;
    tx_start = 1'b1;
    wait_done("b00");
    check("b00_low_run", last_run, 576);
    gap = 1;
    tx_start = 1'b0;
    @(negedge clk);
    if (tx === 1'b1) gap++;
    tx_dato_in = 8'hFF;
    tx_start = 1'b1;
    n = 0;
    while (tx === 1'b1 && n < 50) begin
      @(negedge clk);
      if (tx === 1'b1) gap++;
      n++;
    end
    check("b2b_gap_ge2", {31'd0, gap >= 2}, 1);
    wait_done("bFF");
    check("bFF_low_run", last_run, 64);
    tx_start = 1'b0;
    repeat (5) @(negedge clk);

    // inputs disturbed mid-frame
    tx_dato_in = 8'h0F;
    tx_start = 1'b1;
    capture("b0F_disturb", 10'b1000011110, 1'b1);
    tx_start = 1'b0;
    repeat (5) @(negedge clk);

    // reset during data bit 5
    tx_dato_in = 8'h00;
    tx_start = 1'b1;
    n = 0;
    while (tx !== 1'b0 && n < 300) begin @(negedge clk); n++; end
    repeat (6 * BIT + 20) @(negedge clk);
    base = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("rst_async_tx", {31'd0, tx}, 1);
    check("rst_async_busy", {31'd0, tx_busy}, 0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (200) @(negedge clk);
    check("rst_no_done", done_cnt - base, 0);
    check("rst_start_held_idle", {31'd0, tx_busy}, 0);
    tx_dato_in = 8'h81;
    tx_start = 1'b0;
    @(negedge clk);
    tx_start = 1'b1;
    capture("b81", 10'b1100000010, 1'b0);
    tx_start = 1'b0;
    repeat (5) @(negedge clk);
    check("b81_one_done", done_cnt - base, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter that sits directly downstream of the debug unit. It accepts one byte on `tx_dato_in` when `tx_start` is raised. It then shifts the byte out on `tx` as a standard 8N1 frame at a baud rate set by an internal divider, and pulses `tx_done` when the stop bit completes. It shares its clock with the debug unit and the UART receiver.

## Interface
Parameters:
- `D_BIT`, default 8: data bits per frame, sent LSB first. Legal range 5..8.
- `SB_TICK`, default 16: stop-bit length in oversampling ticks; 16 gives 1 stop bit, 32 gives 2. Legal range 16..32.
- `DVSR`, default 163: clocks per oversampling tick, giving 16 ticks per bit (163 ≈ 50 MHz / (16·19200)). Minimum 2.

Ports:
- `clk`, input, 1: system clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `tx_start`, input, 1: level request from the debug unit; held high until `tx_done` is seen.
- `tx_dato_in`, input, 8: byte to send. Bits [D_BIT-1:0] are used.
- `tx_done`, output, 1: one-cycle pulse at end of frame.
- `tx_busy`, output, 1: high from launch until the `tx_done` cycle, inclusive.
- `tx`, output, 1: serial line, registered, idles at 1.

## Operation
- Reset asynchronously forces: state IDLE, `tx`=1, `tx_done`=0, `tx_busy`=0, `armed`=0, all counters 0.
- `armed` is set on any clock edge where `tx_start`=0 is sampled. A frame launches only on an edge where the state is IDLE, `tx_start`=1 and `armed`=1.
  - At launch: latch `tx_dato_in` into the shift register, clear `armed` and the baud counter, enter START.
  - This arming prevents a second frame while the debug unit's `tx_start` is still high after `tx_done`.
  - If `tx_start` is high at reset release, nothing is sent until `tx_start` has been seen low.
- Baud counter runs 0..DVSR-1 only outside IDLE. The tick pulse occurs when the count is DVSR-1; the counter then wraps to 0.
- State machine is one-hot: IDLE=0001, START=0010, DATA=0100, STOP=1000. Tick counter `s` is 5 bits; bit counter `n` is 3 bits.
  - IDLE: `tx`=1. On launch, go to START with `s`=0.
  - START: `tx`=0. On the tick where `s`=15, clear `s` and `n`, go to DATA. Otherwise increment `s` on each tick.
  - DATA: `tx`=shreg[0]. On the tick where `s`=15:
    - shift shreg right by one and clear `s`;
    - if `n`=D_BIT-1, go to STOP; otherwise increment `n`.
  - STOP: `tx`=1. On the tick where `s`=SB_TICK-1, go to IDLE and assert `tx_done` for exactly one cycle.
  - Undefined state codes go to IDLE with `tx`=1.
- Inputs are ignored between launch and `tx_done`:
  - `tx_start` falling mid-frame does not abort the frame; it only re-arms.
  - `tx_dato_in` changes have no effect.
- `tx` is driven from a register, so it has no combinational glitches.

## Timing
- Launch edge E: `tx` goes 0 and `tx_busy` goes 1 in the cycle following E.
- Each of the start bit and the D_BIT data bits lasts exactly 16·DVSR clocks.
- The stop bit lasts SB_TICK·DVSR clocks.
- `tx_done` is high in the first cycle after the stop bit ends. That cycle is already IDLE with `tx`=1. `tx_busy` falls on the following edge.
- From the first low cycle of `tx` to the `tx_done` cycle: (16·(1+D_BIT)+SB_TICK)·DVSR clocks. With defaults this is 160·DVSR.
- Earliest next launch is the edge after `tx_done`, provided `tx_start` was sampled low at or after `tx_done`. With the debug unit handshake (start drops the cycle after done, then re-raises), back-to-back frames have at least 2 idle cycles of `tx`=1 between them.
- Reset asserted mid-frame: `tx` goes to 1 asynchronously and `tx_done` is never pulsed for the aborted frame.

## Test plan
Benches use DVSR=4, so one bit is 64 clocks.
- Reset then idle: hold `tx_start`=0 for 1000 clocks -> `tx`=1, `tx_done`=0, `tx_busy`=0 throughout.
- Single byte 0x55: raise `tx_start` and hold it until `tx_done` -> `tx` shows 0,1,0,1,0,1,0,1,0,1, each bit 64 clocks long. Exactly one `tx_done` pulse occurs 640 clocks after `tx` first falls.
- Held `tx_start`: keep `tx_start`=1 for 3000 clocks with byte 0xA3 -> exactly one frame (0,1,1,0,0,0,1,0,1,1) and one `tx_done`, then `tx` stays 1.
- Back-to-back bytes: drive 0x00 then 0xFF using the debug unit handshake -> two frames with at least 2 idle cycles between them.
  - 0x00 frame: `tx` low for 576 clocks, then high.
  - 0xFF frame: `tx` low for 64 clocks only.
- Mid-frame disturbance: change `tx_dato_in` from 0x0F to 0xF0 and drop `tx_start` during data bit 3 -> bits sent match 0x0F and `tx_done` timing is unchanged.
- Reset mid-frame: assert `reset` during data bit 5 of 0x00 -> `tx`=1 within the same cycle, no `tx_done`. After release, a new 0x81 frame is sent correctly once `tx_start` has gone 0 then 1.
